exc_cp0: RTL and testbench

EXC_CP0 -- requirements
Module: exc_cp0

---
 rtl/exc_cp0.sv | 151 +++++++++++++++
 tb/tb_exc_cp0.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exc_cp0.sv
// exc_cp0 -- MIPS-style coprocessor 0 for exception and interrupt control.
//
// Holds SR (12), Cause (13), EPC (14) and PRId (15). It decides, in the
// same cycle as the cause, whether the pipeline must take an exception:
// a synchronous exception from the M stage or an enabled hardware
// interrupt.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   PC_M       PC of the M-stage instruction
//   Exc_M      prioritised synchronous exception flag of the M stage
//   ExcCode_M  code for Exc_M (AdEL=4, AdES=5, RI=10, Ov=12)
//   BD_M       M-stage instruction is in a branch delay slot
//   Eret_M     M-stage instruction is eret
//   HWInt      level-sensitive hardware interrupt lines
//   WE         mtc0 write enable
//   A1         mfc0 read register number
//   A2         mtc0 write register number
//   DIn        mtc0 write data
//   DOut       mfc0 read data (combinational, no write bypass)
//   EPC_out    current EPC, the eret target
//   Req        take exception: flush and fetch from the handler
//
// Configuration
//   CP0_BD_EN  when defined, Cause.BD is tracked and a delay-slot victim
//              records EPC = aligned PC_M - 4 so the branch is replayed.
//              When undefined, BD reads 0 and BD_M is ignored.
module exc_cp0 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_M,
  input  logic        Exc_M,
  input  logic [4:0]  ExcCode_M,
  input  logic        BD_M,
  input  logic        Eret_M,
  input  logic [5:0]  HWInt,
  input  logic        WE,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic [31:0] EPC_out,
  output logic        Req
);

  localparam logic [4:0]  REG_SR    = 5'd12;
  localparam logic [4:0]  REG_CAUSE = 5'd13;
  localparam logic [4:0]  REG_EPC   = 5'd14;
  localparam logic [4:0]  REG_PRID  = 5'd15;
  localparam logic [31:0] PRID_VAL  = 32'h4255_4141;
  localparam logic [4:0]  CODE_INT  = 5'd0;

  // Architectural state
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  // Request decode
  logic        int_req;
  logic [4:0]  exc_code_sel;
  logic [31:0] pc_aligned;
  logic [31:0] epc_capture;

  assign int_req      = sr_ie & ~sr_exl & (|(HWInt & sr_im));
  assign Req          = int_req | Exc_M;
  // An interrupt wins over a simultaneous synchronous exception.
  assign exc_code_sel = int_req ? CODE_INT : ExcCode_M;
  assign pc_aligned   = {PC_M[31:2], 2'b00};

`ifdef CP0_BD_EN
  // A delay-slot victim returns to its branch so the branch re-executes.
  assign epc_capture = BD_M ? (pc_aligned - 32'd4) : pc_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_bd <= 1'b0;
    end else if (Req && !sr_exl) begin
      cause_bd <= BD_M;
    end
  end

  logic unused_pc_low;
  assign unused_pc_low = ^PC_M[1:0];
`else
  assign epc_capture = pc_aligned;
  assign cause_bd    = 1'b0;

  logic unused_bd_pc;
  assign unused_bd_pc = ^{PC_M[1:0], BD_M};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later statements in this block deliberately
  // override earlier ones (eret clearing EXL beats an mtc0 write to SR).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        // Any pending mtc0 write and eret are dropped when an exception is taken.
        cause_exc <= exc_code_sel;
        if (!sr_exl) begin
          sr_exl <= 1'b1;
          epc    <= epc_capture;
        end
      end else begin
        if (WE) begin
          case (A2)
            REG_SR: begin
              sr_im  <= DIn[15:10];
              sr_exl <= DIn[1];
              sr_ie  <= DIn[0];
            end
            REG_EPC: epc <= {DIn[31:2], 2'b00};
            default: ;
          endcase
        end
        if (Eret_M) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // NOTE: the read mux assigns DOut a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:    DOut = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
      REG_CAUSE: DOut = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'b00};
      REG_EPC:   DOut = epc;
      REG_PRID:  DOut = PRID_VAL;
      default:   DOut = '0;
    endcase
  end

  assign EPC_out = epc;

endmodule

// File: tb/tb_exc_cp0.sv
// tb_exc_cp0 -- directed self-checking bench for exc_cp0.
// Inputs change 1 time unit after a rising edge; outputs are sampled
// within the same cycle, well away from the next edge.
module tb_exc_cp0;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_M;
  logic        Exc_M;
  logic [4:0]  ExcCode_M;
  logic        BD_M;
  logic        Eret_M;
  logic [5:0]  HWInt;
  logic        WE;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic [31:0] EPC_out;
  logic        Req;

  int total = 0;
  int bad   = 0;

  exc_cp0 dut (
    .clk(clk), .rst_n(rst_n), .PC_M(PC_M), .Exc_M(Exc_M),
    .ExcCode_M(ExcCode_M), .BD_M(BD_M), .Eret_M(Eret_M), .HWInt(HWInt),
    .WE(WE), .A1(A1), .A2(A2), .DIn(DIn), .DOut(DOut),
    .EPC_out(EPC_out), .Req(Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PC_M = 32'h0; Exc_M = 1'b0; ExcCode_M = 5'd0; BD_M = 1'b0;
    Eret_M = 1'b0; HWInt = 6'd0; WE = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL rst_sr got=%h exp=%h", DOut, 32'h0); end
    total++; if (Req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", Req); end
    Exc_M = 1'b1; #1;
    total++; if (Req !== 1'b1) begin bad++; $display("FAIL rst_req_exc got=%b exp=1", Req); end
    Exc_M = 1'b0;
    tick();
    rst_n = 1'b1;
    A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL rd_sr got=%h exp=%h", DOut, 32'h0); end
    A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL rd_cause got=%h exp=%h", DOut, 32'h0); end
    A1 = 5'd14; #1;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL rd_epc got=%h exp=%h", DOut, 32'h0); end
    A1 = 5'd15; #1;
    total++; if (DOut !== 32'h4255_4141) begin bad++; $display("FAIL rd_prid got=%h exp=%h", DOut, 32'h4255_4141); end
    A1 = 5'd3; #1;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL rd_unlisted got=%h exp=0", DOut); end
  endtask

  task automatic test_mtc0();
    WE = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677;
    tick();
    WE = 1'b0; A1 = 5'd14; #1;
    total++; if (DOut !== 32'h1234_5674) begin bad++; $display("FAIL mtc0_epc got=%h exp=%h", DOut, 32'h1234_5674); end
    total++; if (EPC_out !== 32'h1234_5674) begin bad++; $display("FAIL mtc0_epc_out got=%h exp=%h", EPC_out, 32'h1234_5674); end
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0; A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL mtc0_cause_ign got=%h exp=0", DOut); end
    WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0; A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_FC03) begin bad++; $display("FAIL mtc0_sr_mask got=%h exp=%h", DOut, 32'h0000_FC03); end
    // write SR with EXL=1 while eret: eret clear wins
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; Eret_M = 1'b1;
    tick();
    WE = 1'b0; Eret_M = 1'b0; A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_0401) begin bad++; $display("FAIL we_eret_sr got=%h exp=%h", DOut, 32'h0000_0401); end
  endtask

  task automatic test_interrupt();
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    WE = 1'b0; HWInt = 6'b000001; PC_M = 32'h3010; #1;
    total++; if (Req !== 1'b1) begin bad++; $display("FAIL int_req got=%b exp=1", Req); end
    tick();
    A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_0403) begin bad++; $display("FAIL int_sr got=%h exp=%h", DOut, 32'h0000_0403); end
    A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0000_0400) begin bad++; $display("FAIL int_cause got=%h exp=%h", DOut, 32'h0000_0400); end
    total++; if (EPC_out !== 32'h3010) begin bad++; $display("FAIL int_epc got=%h exp=%h", EPC_out, 32'h3010); end
    total++; if (Req !== 1'b0) begin bad++; $display("FAIL int_req_masked got=%b exp=0", Req); end
    HWInt = 6'd0; Eret_M = 1'b1;
    tick();
    Eret_M = 1'b0; A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_0401) begin bad++; $display("FAIL int_eret_sr got=%h exp=%h", DOut, 32'h0000_0401); end
  endtask

  task automatic test_exception_bd();
    Exc_M = 1'b1; ExcCode_M = 5'd12; BD_M = 1'b1; PC_M = 32'h3024; #1;
    total++; if (Req !== 1'b1) begin bad++; $display("FAIL exc_req got=%b exp=1", Req); end
    tick();
    Exc_M = 1'b0; BD_M = 1'b0; A1 = 5'd13; #1;
`ifdef CP0_BD_EN
    total++; if (DOut !== 32'h8000_0030) begin bad++; $display("FAIL exc_cause got=%h exp=%h", DOut, 32'h8000_0030); end
    total++; if (EPC_out !== 32'h3020) begin bad++; $display("FAIL exc_epc got=%h exp=%h", EPC_out, 32'h3020); end
`else
    total++; if (DOut !== 32'h0000_0030) begin bad++; $display("FAIL exc_cause got=%h exp=%h", DOut, 32'h0000_0030); end
    total++; if (EPC_out !== 32'h3024) begin bad++; $display("FAIL exc_epc got=%h exp=%h", EPC_out, 32'h3024); end
`endif
    Eret_M = 1'b1;
    tick();
    Eret_M = 1'b0;
  endtask

  task automatic test_nested();
    // interrupt and exception together: interrupt wins, code 0; unaligned PC
    HWInt = 6'b000001; Exc_M = 1'b1; ExcCode_M = 5'd12; PC_M = 32'h3012;
    tick();
    HWInt = 6'd0; A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0000_0400) begin bad++; $display("FAIL prio_cause got=%h exp=%h", DOut, 32'h0000_0400); end
    total++; if (EPC_out !== 32'h3010) begin bad++; $display("FAIL prio_epc got=%h exp=%h", EPC_out, 32'h3010); end
    ExcCode_M = 5'd10; PC_M = 32'h3050; #1;
    total++; if (Req !== 1'b1) begin bad++; $display("FAIL nest_req got=%b exp=1", Req); end
    tick();
    Exc_M = 1'b0; A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0000_0028) begin bad++; $display("FAIL nest_cause got=%h exp=%h", DOut, 32'h0000_0028); end
    total++; if (EPC_out !== 32'h3010) begin bad++; $display("FAIL nest_epc got=%h exp=%h", EPC_out, 32'h3010); end
    A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_0403) begin bad++; $display("FAIL nest_sr got=%h exp=%h", DOut, 32'h0000_0403); end
    Eret_M = 1'b1;
    tick();
    Eret_M = 1'b0; A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_0401) begin bad++; $display("FAIL nest_eret_sr got=%h exp=%h", DOut, 32'h0000_0401); end
    total++; if (EPC_out !== 32'h3010) begin bad++; $display("FAIL nest_eret_epc got=%h exp=%h", EPC_out, 32'h3010); end
  endtask

  task automatic test_write_vs_req();
    HWInt = 6'b000001; WE = 1'b1; A2 = 5'd14; DIn = 32'h5000; PC_M = 32'h3060;
    tick();
    WE = 1'b0; HWInt = 6'd0; #1;
    total++; if (EPC_out !== 32'h3060) begin bad++; $display("FAIL wr_drop_epc got=%h exp=%h", EPC_out, 32'h3060); end
    Eret_M = 1'b1;
    tick();
    // eret together with an exception: exception wins, EXL set
    Eret_M = 1'b1; Exc_M = 1'b1; ExcCode_M = 5'd4; PC_M = 32'h3070;
    tick();
    Eret_M = 1'b0; Exc_M = 1'b0; A1 = 5'd12; #1;
    total++; if (DOut !== 32'h0000_0403) begin bad++; $display("FAIL eret_lose_sr got=%h exp=%h", DOut, 32'h0000_0403); end
    A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0000_0010) begin bad++; $display("FAIL eret_lose_cause got=%h exp=%h", DOut, 32'h0000_0010); end
    total++; if (EPC_out !== 32'h3070) begin bad++; $display("FAIL eret_lose_epc got=%h exp=%h", EPC_out, 32'h3070); end
  endtask

  task automatic test_async_reset();
    // still in handler (EXL=1); make Cause.IP nonzero without interrupting
    HWInt = 6'b000010;
    tick();
    A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0000_0810) begin bad++; $display("FAIL pre_rst_cause got=%h exp=%h", DOut, 32'h0000_0810); end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    A1 = 5'd12; #0;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL async_sr got=%h exp=0", DOut); end
    A1 = 5'd13; #0;
    total++; if (DOut !== 32'h0) begin bad++; $display("FAIL async_cause got=%h exp=0", DOut); end
    total++; if (EPC_out !== 32'h0) begin bad++; $display("FAIL async_epc got=%h exp=0", EPC_out); end
    tick();
    rst_n = 1'b1;
    tick();
    A1 = 5'd13; #1;
    total++; if (DOut !== 32'h0000_0800) begin bad++; $display("FAIL post_rst_ip got=%h exp=%h", DOut, 32'h0000_0800); end
  endtask

  initial begin
    test_reset();
    test_mtc0();
    test_interrupt();
    test_exception_bd();
    test_nested();
    test_write_vs_req();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
